// File: rtl/segments_update_master_if.sv
// Signal bundle between the hex-value requesters, the segment update master and the display PIO.
// The master modport is the update master's own view of the bundle.
interface segments_update_master_if;
   logic        req0;
   logic [15:0] data0;
   logic [3:0]  dp0;
   logic        ack0;
   logic        req1;
   logic [15:0] data1;
   logic [3:0]  dp1;
   logic        ack1;
   logic [3:0]  blank_mask;
   logic        blink_en;
   logic        busy;
   logic [1:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [31:0] avm_writedata;

   modport master (
      input  req0, data0, dp0, req1, data1, dp1, blank_mask, blink_en,
      output ack0, ack1, busy, avm_address, avm_chipselect, avm_write_n, avm_writedata
   );

   modport slave (
      output req0, data0, dp0, req1, data1, dp1, blank_mask, blink_en,
      input  ack0, ack1, busy, avm_address, avm_chipselect, avm_write_n, avm_writedata
   );
endinterface

// File: rtl/segments_update_master.sv
// Seven-segment update master: arbitrates two hex requesters, encodes the value with dp/blank/blink,
// and issues one Avalon-MM write to the display PIO per transaction.
//
// state  | meaning
// IDLE   | waiting for a request or a pending blink refresh
// ENCODE | two cycles building the segment word from the stored value
// WRITE  | chipselect/write_n asserted for one cycle
// ACK    | ack pulse to the owner; arbitrates like IDLE so back-to-back writes take 4 cycles
module segments_update_master #(
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter int unsigned BLINK_DIV  = 25000000,
   parameter int unsigned PIO_ADDR   = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   segments_update_master_if.master bus
);

   localparam int unsigned          CNT_W   = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(BLINK_DIV - 1);
   localparam logic [1:0]           ADDR    = 2'(PIO_ADDR);

   typedef enum logic [1:0] {ST_IDLE, ST_ENCODE, ST_WRITE, ST_ACK} state_t;

   state_t           state_q, state_d;
   logic             enc_step_q, enc_step_d;
   logic             last_grant_q;
   logic             txn_owner_q;
   logic             txn_refresh_q;
   logic [15:0]      value_q;
   logic [3:0]       dp_q;
   logic [3:0]       mask_q;
   logic [CNT_W-1:0] blink_cnt_q;
   logic             blink_phase_q;
   logic             blink_en_q;
   logic             refresh_pending_q;
   logic             ack0_q, ack1_q, busy_q, cs_q, write_n_q;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      enc_word;
   logic             grant, grant_owner, refresh_go;
   logic             blink_wrap, refresh_set;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   endfunction

   always_comb begin
      enc_word = '0;
      for (int i = 0; i < 4; i++) begin
         if (!mask_q[i] && !(bus.blink_en && blink_phase_q))
            enc_word[8*i +: 8] = {dp_q[i], seg7(value_q[4*i +: 4])};
      end
      if (ACTIVE_LOW)
         enc_word = ~enc_word;
   end

   always_comb begin
      state_d     = state_q;
      enc_step_d  = enc_step_q;
      wdata_d     = wdata_q;
      grant       = 1'b0;
      grant_owner = 1'b0;
      refresh_go  = 1'b0;
      case (state_q)
         ST_IDLE, ST_ACK: begin
            state_d = ST_IDLE;
            if (bus.req0 || bus.req1) begin
               grant       = 1'b1;
               grant_owner = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
               state_d     = ST_ENCODE;
               enc_step_d  = 1'b0;
            end else if (refresh_pending_q) begin
               refresh_go = 1'b1;
               state_d    = ST_ENCODE;
               enc_step_d = 1'b0;
            end
         end
         ST_ENCODE: begin
            wdata_d = enc_word;
            if (enc_step_q)
               state_d = ST_WRITE;
            else
               enc_step_d = 1'b1;
         end
         ST_WRITE: state_d = ST_ACK;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         enc_step_q    <= 1'b0;
         wdata_q       <= '0;
         cs_q          <= 1'b0;
         write_n_q     <= 1'b1;
         busy_q        <= 1'b0;
         ack0_q        <= 1'b0;
         ack1_q        <= 1'b0;
         last_grant_q  <= 1'b1;
         txn_owner_q   <= 1'b0;
         txn_refresh_q <= 1'b0;
         value_q       <= '0;
         dp_q          <= '0;
         mask_q        <= '0;
      end else begin
         state_q    <= state_d;
         enc_step_q <= enc_step_d;
         wdata_q    <= wdata_d;
         cs_q       <= (state_d == ST_WRITE);
         write_n_q  <= (state_d != ST_WRITE);
         busy_q     <= (state_d != ST_IDLE);
         ack0_q     <= (state_d == ST_ACK) && !txn_refresh_q && !txn_owner_q;
         ack1_q     <= (state_d == ST_ACK) && !txn_refresh_q && txn_owner_q;
         if (grant) begin
            value_q       <= grant_owner ? bus.data1 : bus.data0;
            dp_q          <= grant_owner ? bus.dp1 : bus.dp0;
            mask_q        <= bus.blank_mask;
            last_grant_q  <= grant_owner;
            txn_owner_q   <= grant_owner;
            txn_refresh_q <= 1'b0;
         end else if (refresh_go) begin
            txn_refresh_q <= 1'b1;
         end
      end
   end

   // A new refresh request wins over the clear of one just being served.
   assign blink_wrap  = (blink_cnt_q == CNT_MAX);
   assign refresh_set = (blink_wrap && bus.blink_en) || (bus.blink_en != blink_en_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q       <= '0;
         blink_phase_q     <= 1'b0;
         blink_en_q        <= 1'b0;
         refresh_pending_q <= 1'b0;
      end else begin
         blink_en_q <= bus.blink_en;
         if (blink_wrap) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
         if (refresh_set)
            refresh_pending_q <= 1'b1;
         else if (refresh_go)
            refresh_pending_q <= 1'b0;
      end
   end

   assign bus.ack0           = ack0_q;
   assign bus.ack1           = ack1_q;
   assign bus.busy           = busy_q;
   assign bus.avm_address    = ADDR;
   assign bus.avm_chipselect = cs_q;
   assign bus.avm_write_n    = write_n_q;
   assign bus.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_segments_update_master.sv
// Bench for segments_update_master: random requests checked against a table-driven display model.
module tb_segments_update_master;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   segments_update_master_if bus();
   segments_update_master_if bus_ah();

   segments_update_master #(.ACTIVE_LOW(1'b1), .BLINK_DIV(4), .PIO_ADDR(0)) u_dut (
      .clk(clk), .reset(reset), .bus(bus.master));
   segments_update_master #(.ACTIVE_LOW(1'b0), .BLINK_DIV(4), .PIO_ADDR(2)) u_dut_ah (
      .clk(clk), .reset(reset), .bus(bus_ah.master));

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [31:0] wr_q[$];
   int          wr_cyc[$];
   int          ack_own[$];
   int          ack_cyc[$];
   logic [31:0] wr_ah_q[$];
   logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference display model: sum of per-digit codes placed at byte positions.
   function automatic logic [31:0] model_word(input logic [15:0] v, input logic [3:0] dp,
                                              input logic [3:0] mask, input bit active_low,
                                              input bit blank_all);
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < 4; i++) begin
         int nib;
         nib = (v >> (4 * i)) % 16;
         if (!mask[i] && !blank_all)
            w = w + (32'(seg_tab[nib]) + (dp[i] ? 32'd128 : 32'd0)) * (32'd1 << (8 * i));
      end
      return active_low ? ~w : w;
   endfunction

   always begin
      @(posedge clk);
      #2;
      cyc++;
      if (bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0) begin
         wr_q.push_back(bus.avm_writedata);
         wr_cyc.push_back(cyc);
      end
      if (bus.ack0 === 1'b1) begin ack_own.push_back(0); ack_cyc.push_back(cyc); end
      if (bus.ack1 === 1'b1) begin ack_own.push_back(1); ack_cyc.push_back(cyc); end
      if (bus_ah.avm_chipselect === 1'b1 && bus_ah.avm_write_n === 1'b0)
         wr_ah_q.push_back(bus_ah.avm_writedata);
   end

   task automatic clear_mon();
      wr_q.delete(); wr_cyc.delete(); ack_own.delete(); ack_cyc.delete(); wr_ah_q.delete();
   endtask

   task automatic wait_writes(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (wr_q.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic do_req(input int who, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] mask, output bit ok);
      int n0;
      n0 = ack_own.size();
      @(negedge clk);
      bus.blank_mask = mask;
      if (who == 0) begin bus.data0 = d; bus.dp0 = dp; bus.req0 = 1'b1; end
      else          begin bus.data1 = d; bus.dp1 = dp; bus.req1 = 1'b1; end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack_own.size() > n0) begin ok = 1'b1; break; end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      bus.data0 = 16'h5A5A; bus.dp0 = 4'h3; bus.blank_mask = 4'h0; bus.req0 = 1'b1;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      n_checks++; if (bus.avm_chipselect !== 1'b0) $display("FAIL rst_cs: got %b want 0", bus.avm_chipselect); else n_pass++;
      n_checks++; if (bus.avm_write_n !== 1'b1) $display("FAIL rst_write_n: got %b want 1", bus.avm_write_n); else n_pass++;
      n_checks++; if (bus.avm_writedata !== 32'h0) $display("FAIL rst_wdata: got %h want 00000000", bus.avm_writedata); else n_pass++;
      n_checks++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) $display("FAIL rst_ack: got %b%b want 00", bus.ack0, bus.ack1); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
      n_checks++; if (bus.avm_address !== 2'd0) $display("FAIL rst_addr: got %0d want 0", bus.avm_address); else n_pass++;
      bus.req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      clear_mon();
   endtask

   task automatic test_single_write();
      logic [31:0] exp;
      exp = model_word(16'h1234, 4'h0, 4'h0, 1'b1, 1'b0);
      @(negedge clk);
      bus.data0 = 16'h1234; bus.dp0 = 4'h0; bus.blank_mask = 4'h0; bus.req0 = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1 || bus.avm_chipselect !== 1'b0) $display("FAIL sw_k0: busy=%b cs=%b want busy=1 cs=0", bus.busy, bus.avm_chipselect); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1 || bus.avm_chipselect !== 1'b0) $display("FAIL sw_k1: busy=%b cs=%b want busy=1 cs=0", bus.busy, bus.avm_chipselect); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.avm_chipselect !== 1'b1 || bus.avm_write_n !== 1'b0) $display("FAIL sw_strobe: cs=%b wn=%b want cs=1 wn=0", bus.avm_chipselect, bus.avm_write_n); else n_pass++;
      n_checks++; if (bus.avm_writedata !== exp) $display("FAIL sw_wdata: got %h want %h", bus.avm_writedata, exp); else n_pass++;
      n_checks++; if (bus.ack0 !== 1'b0) $display("FAIL sw_early_ack: got %b want 0", bus.ack0); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.avm_chipselect !== 1'b0) $display("FAIL sw_ack: ack0=%b ack1=%b cs=%b want 1 0 0", bus.ack0, bus.ack1, bus.avm_chipselect); else n_pass++;
      bus.req0 = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) $display("FAIL sw_done: ack0=%b busy=%b want 0 0", bus.ack0, bus.busy); else n_pass++;
      clear_mon();
   endtask

   task automatic test_dp_blank();
      logic [15:0] td [4] = '{16'h1234, 16'h1234, 16'hABCD, 16'h0F96};
      logic [3:0]  tp [4] = '{4'b0001, 4'b0000, 4'b1010, 4'b1111};
      logic [3:0]  tm [4] = '{4'b0000, 4'b1000, 4'b0101, 4'b0010};
      int          tw [4] = '{0, 0, 1, 1};
      bit ok;
      logic [31:0] exp;
      for (int t = 0; t < 4; t++) begin
         clear_mon();
         do_req(tw[t], td[t], tp[t], tm[t], ok);
         exp = model_word(td[t], tp[t], tm[t], 1'b1, 1'b0);
         n_checks++;
         if (!ok || wr_q.size() != 1) $display("FAIL dpb_count_%0d: ack=%0d writes=%0d want 1 1", t, ok, wr_q.size());
         else if (wr_q[0] !== exp) $display("FAIL dpb_wdata_%0d: got %h want %h", t, wr_q[0], exp);
         else if (ack_own[0] != tw[t]) $display("FAIL dpb_owner_%0d: got %0d want %0d", t, ack_own[0], tw[t]);
         else n_pass++;
      end
      // active-high instance with a non-zero PIO address
      @(negedge clk);
      bus_ah.data1 = 16'hFFFF; bus_ah.dp1 = 4'h0; bus_ah.blank_mask = 4'h0; bus_ah.req1 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_ah.avm_chipselect === 1'b1) begin
            ok = 1'b1;
            n_checks++; if (bus_ah.avm_address !== 2'd2) $display("FAIL ah_addr: got %0d want 2", bus_ah.avm_address); else n_pass++;
            break;
         end
      end
      for (int i = 0; i < 5 && bus_ah.ack1 !== 1'b1; i++) @(negedge clk);
      bus_ah.req1 = 1'b0;
      exp = model_word(16'hFFFF, 4'h0, 4'h0, 1'b0, 1'b0);
      n_checks++;
      if (!ok || wr_ah_q.size() != 1) $display("FAIL ah_count: seen=%0d writes=%0d want 1 1", ok, wr_ah_q.size());
      else if (wr_ah_q[0] !== exp) $display("FAIL ah_wdata: got %h want %h", wr_ah_q[0], exp);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_random();
      bit ok;
      int who;
      logic [15:0] d;
      logic [3:0] dp, m;
      logic [31:0] exp;
      for (int t = 0; t < 16; t++) begin
         clear_mon();
         who = int'($urandom_range(0, 1));
         d   = 16'($urandom);
         dp  = 4'($urandom);
         m   = 4'($urandom);
         do_req(who, d, dp, m, ok);
         exp = model_word(d, dp, m, 1'b1, 1'b0);
         n_checks++;
         if (!ok || wr_q.size() != 1) $display("FAIL rnd_count_%0d: ack=%0d writes=%0d want 1 1", t, ok, wr_q.size());
         else if (wr_q[0] !== exp || ack_own[0] != who) $display("FAIL rnd_%0d: got %h/%0d want %h/%0d", t, wr_q[0], ack_own[0], exp, who);
         else n_pass++;
      end
   endtask

   task automatic test_drop_inflight();
      bit ok;
      logic [31:0] exp;
      clear_mon();
      exp = model_word(16'hC0DE, 4'b0100, 4'b0001, 1'b1, 1'b0);
      @(negedge clk);
      bus.data0 = 16'hC0DE; bus.dp0 = 4'b0100; bus.blank_mask = 4'b0001; bus.req0 = 1'b1;
      @(negedge clk);
      bus.req0 = 1'b0; bus.data0 = 16'h9999; bus.dp0 = 4'hF; bus.blank_mask = 4'hA;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack_own.size() > 0) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok || wr_q.size() != 1) $display("FAIL drop_count: ack=%0d writes=%0d want 1 1", ok, wr_q.size());
      else if (wr_q[0] !== exp || ack_own[0] != 0) $display("FAIL drop_wdata: got %h/%0d want %h/0", wr_q[0], ack_own[0], exp);
      else n_pass++;
      bus.blank_mask = 4'h0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit ok;
      int last, bad, exp_own, n0;
      logic r0, r1;
      logic [15:0] d0, d1;
      logic [31:0] exp;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      clear_mon();
      d0 = 16'($urandom); d1 = 16'($urandom);
      bus.data0 = d0; bus.data1 = d1; bus.dp0 = 4'h0; bus.dp1 = 4'h0; bus.blank_mask = 4'h0;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ack_own.size() >= 8) begin ok = 1'b1; break; end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      n_checks++; if (!ok) $display("FAIL b2b_timeout: acks=%0d want 8", ack_own.size()); else n_pass++;
      if (ok) begin
         for (int i = 0; i < 8; i++) begin
            n_checks++; if (ack_own[i] != i % 2) $display("FAIL b2b_owner_%0d: got %0d want %0d", i, ack_own[i], i % 2); else n_pass++;
         end
         bad = 0;
         for (int i = 1; i < 8; i++) if (ack_cyc[i] - ack_cyc[i-1] != 4) bad++;
         for (int i = 0; i < 8; i++)
            if (wr_q[i] !== model_word((i % 2) ? d1 : d0, 4'h0, 4'h0, 1'b1, 1'b0)) bad++;
         n_checks++; if (bad != 0) $display("FAIL b2b_rate_data: got %0d errors want 0", bad); else n_pass++;
      end
      @(negedge clk);
      last = 1;
      for (int t = 0; t < 12; t++) begin
         clear_mon();
         r0 = 1'($urandom); r1 = 1'($urandom);
         if (!r0 && !r1) r0 = 1'b1;
         d0 = 16'($urandom); d1 = 16'($urandom);
         exp_own = (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
         exp = model_word(exp_own ? d1 : d0, 4'h0, 4'h0, 1'b1, 1'b0);
         n0 = 0;
         bus.data0 = d0; bus.data1 = d1; bus.req0 = r0; bus.req1 = r1;
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_own.size() > n0) begin ok = 1'b1; break; end
         end
         bus.req0 = 1'b0; bus.req1 = 1'b0;
         n_checks++;
         if (!ok || wr_q.size() != 1) $display("FAIL rr_count_%0d: ack=%0d writes=%0d want 1 1", t, ok, wr_q.size());
         else if (ack_own[0] != exp_own || wr_q[0] !== exp) $display("FAIL rr_%0d: got %0d/%h want %0d/%h", t, ack_own[0], wr_q[0], exp_own, exp);
         else n_pass++;
         last = exp_own;
         @(negedge clk);
      end
   endtask

   task automatic test_blink();
      bit ok;
      int n, bad;
      logic [31:0] val, blank, ev0, ev1;
      logic [15:0] d0, d1;
      val   = model_word(16'h1234, 4'h0, 4'h0, 1'b1, 1'b0);
      blank = model_word(16'h1234, 4'h0, 4'h0, 1'b1, 1'b1);
      do_req(0, 16'h1234, 4'h0, 4'h0, ok);
      clear_mon();
      @(negedge clk);
      bus.blink_en = 1'b1;
      wait_writes(10, 80, ok);
      n_checks++; if (!ok) $display("FAIL blink_timeout: writes=%0d want 10", wr_q.size()); else n_pass++;
      if (ok) begin
         bad = 0;
         for (int i = 3; i < 10; i++) begin
            if (wr_q[i] !== val && wr_q[i] !== blank) bad++;
            if (wr_q[i] === wr_q[i-1]) bad++;
            if (wr_cyc[i] - wr_cyc[i-1] != 4) bad++;
         end
         n_checks++; if (bad != 0) $display("FAIL blink_alt: got %0d errors want 0", bad); else n_pass++;
         n_checks++; if (ack_own.size() != 0) $display("FAIL blink_noack: got %0d acks want 0", ack_own.size()); else n_pass++;
      end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr_cyc.size() > 0 && wr_cyc[$] == cyc && wr_q[$] === blank) begin
            bus.blink_en = 1'b0; ok = 1'b1; break;
         end
      end
      bus.blink_en = 1'b0;
      n = wr_q.size();
      repeat (20) @(negedge clk);
      n_checks++;
      if (!ok || wr_q.size() != n + 1) $display("FAIL blink_restore_count: found=%0d writes=%0d want %0d", ok, wr_q.size(), n + 1);
      else if (wr_q[n] !== val) $display("FAIL blink_restore: got %h want %h", wr_q[n], val);
      else n_pass++;
      // req0 arriving together with a pending refresh
      clear_mon();
      d0 = 16'($urandom); d1 = 16'($urandom);
      ev1 = model_word(d1, 4'h0, 4'h0, 1'b1, 1'b0);
      ev0 = model_word(d0, 4'h0, 4'h0, 1'b1, 1'b0);
      @(negedge clk);
      bus.data1 = d1; bus.dp1 = 4'h0; bus.blank_mask = 4'h0; bus.req1 = 1'b1;
      @(negedge clk);
      bus.blink_en = 1'b1;
      @(negedge clk);
      bus.blink_en = 1'b0; bus.data0 = d0; bus.dp0 = 4'h0; bus.req0 = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.ack1 === 1'b1) bus.req1 = 1'b0;
         if (bus.ack0 === 1'b1) begin bus.req0 = 1'b0; break; end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      repeat (15) @(negedge clk);
      n_checks++;
      if (wr_q.size() != 3 || ack_own.size() != 2) $display("FAIL rfq_count: writes=%0d acks=%0d want 3 2", wr_q.size(), ack_own.size());
      else if (wr_q[0] !== ev1 || wr_q[1] !== ev0 || wr_q[2] !== ev0) $display("FAIL rfq_data: got %h %h %h want %h %h %h", wr_q[0], wr_q[1], wr_q[2], ev1, ev0, ev0);
      else if (ack_own[0] != 1 || ack_own[1] != 0) $display("FAIL rfq_owner: got %0d %0d want 1 0", ack_own[0], ack_own[1]);
      else n_pass++;
   endtask

   task automatic test_abort();
      bit ok;
      logic [31:0] exp;
      clear_mon();
      @(negedge clk);
      bus.data0 = 16'($urandom); bus.dp0 = 4'h0; bus.blank_mask = 4'h0; bus.req0 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.avm_chipselect === 1'b1) begin ok = 1'b1; break; end
      end
      reset = 1'b1;
      #1;
      n_checks++; if (!ok) $display("FAIL abort_nowrite: write strobe not seen want seen"); else n_pass++;
      n_checks++; if (bus.avm_chipselect !== 1'b0 || bus.busy !== 1'b0 || bus.ack0 !== 1'b0) $display("FAIL abort_now: cs=%b busy=%b ack0=%b want 0 0 0", bus.avm_chipselect, bus.busy, bus.ack0); else n_pass++;
      bus.req0 = 1'b0;
      @(negedge clk);
      clear_mon();
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      n_checks++; if (ack_own.size() != 0 || wr_q.size() != 0) $display("FAIL abort_quiet: acks=%0d writes=%0d want 0 0", ack_own.size(), wr_q.size()); else n_pass++;
      do_req(1, 16'h0000, 4'h0, 4'h0, ok);
      exp = model_word(16'h0000, 4'h0, 4'h0, 1'b1, 1'b0);
      n_checks++;
      if (!ok || wr_q.size() != 1) $display("FAIL abort_after_count: ack=%0d writes=%0d want 1 1", ok, wr_q.size());
      else if (wr_q[0] !== exp || ack_own[0] != 1) $display("FAIL abort_after: got %h/%0d want %h/1", wr_q[0], ack_own[0], exp);
      else n_pass++;
   endtask

   initial begin
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;
      bus.dp0 = '0; bus.dp1 = '0; bus.blank_mask = '0; bus.blink_en = 1'b0;
      bus_ah.req0 = 1'b0; bus_ah.req1 = 1'b0; bus_ah.data0 = '0; bus_ah.data1 = '0;
      bus_ah.dp0 = '0; bus_ah.dp1 = '0; bus_ah.blank_mask = '0; bus_ah.blink_en = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_single_write();
      test_dp_blank();
      test_random();
      test_drop_inflight();
      test_back_to_back();
      test_blink();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/segments_update_master.md
Name: segments_update_master

Overview:
- Avalon-MM write master that owns the 32-bit seven-segment display PIO slave (4 digits x 8 bits).
- Arbitrates between two hex-value requesters: req0 is the timer count path, req1 is the CPU/message override.
- Encodes the granted 16-bit hex value into segment codes, applies digit blanking, decimal points and blink, then issues a single-cycle PIO write.
- Sits between the timer logic and the display PIO inside the TimerSoC fabric.

Parameters:
- ACTIVE_LOW, 1: 1 inverts every segment/dp bit (board displays are active-low).
- BLINK_DIV, 25000000: blink half-period in clk cycles; legal range >= 2.
- PIO_ADDR, 0: value driven on avm_address during writes.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 (timer) write request; level, held until ack0.
- data0  in  16  requester 0 value, 4 hex nibbles; nibble i drives digit i.
- dp0  in  4  requester 0 decimal points; bit i=1 lights dp of digit i.
- ack0  out  1  one-cycle pulse when requester 0's write has been issued.
- req1  in  1  requester 1 (override) write request.
- data1  in  16  requester 1 value.
- dp1  in  4  requester 1 decimal points.
- ack1  out  1  one-cycle completion pulse for requester 1.
- blank_mask  in  4  bit i=1 forces digit i fully off; sampled at grant.
- blink_en  in  1  1 alternates the whole display between value and blank.
- busy  out  1  high whenever state != IDLE.
- avm_address  out  2  PIO register address.
- avm_chipselect  out  1  PIO select.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  32  encoded segment word.

Behaviour:
- Reset (async, active-high): state=IDLE; ack0=ack1=0, busy=0, avm_chipselect=0, avm_write_n=1, avm_address=PIO_ADDR, avm_writedata=0. Internal: last_grant=1 (req0 wins first), stored value/dp/mask=0, blink counter=0, blink_phase=0, refresh_pending=0.
- FSM states: IDLE -> ENCODE -> WRITE -> ACK -> IDLE. All outputs registered.
- IDLE: at edge k, if req0|req1 is set, grant and latch data/dp/blank_mask into the stored registers, then go to ENCODE.
  - Both requesting: grant the requester != last_grant (round robin); last_grant updates on grant.
  - No external request and refresh_pending: internal refresh of the stored registers (no ack, last_grant unchanged); clear refresh_pending.
- ENCODE (k..k+1): build avm_writedata.
  - Digit i occupies bits[8i+7:8i]: bit7=dp, bits6:0=gfedcba.
  - Hex table (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - A blanked digit is 0x00, including dp. When blink_en=1 and blink_phase=1, all digits are 0x00.
  - ACTIVE_LOW then inverts all 32 bits.
- WRITE (k+2..k+3): avm_chipselect=1, avm_write_n=0, avm_address=PIO_ADDR for exactly one cycle. The slave has no waitrequest; the write commits at edge k+3.
- ACK (k+3..k+4): the granted ackN=1 for one cycle. IDLE is re-entered at k+4 and a request can be granted at edge k+4. Throughput is 1 write per 4 cycles.
- A request dropped before its ack still completes and still acks. A requester still holding req after its ack is treated as a new request (re-arbitrated).
- Blink counter: free-running 0..BLINK_DIV-1. At wrap, toggle blink_phase and, if blink_en=1, set refresh_pending.
- Any edge of blink_en sets refresh_pending, so the display is restored when blink is disabled.
- refresh_pending set while busy stays pending. Multiple sets collapse into one refresh.
- Reset mid-transaction aborts immediately: chipselect drops, no ack is issued, and no further write occurs.
- data/dp/blank_mask changes after grant do not affect an in-flight write.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> immediately chipselect=0, write_n=1, writedata=0, ack0=ack1=0, busy=0.
- Single write: req0=1, data0=0x1234, dp0=0, mask=0 at edge k -> chipselect=1/write_n=0 in cycle k+2..k+3 with writedata=0xF9A4B099; ack0 pulses k+3..k+4; busy high k..k+4.
- Decimal point and blanking: data0=0x1234, dp0=4'b0001 -> 0xF9A4B019; blank_mask=4'b1000 -> 0xFFA4B099. Data1=0xFFFF, ACTIVE_LOW=0 -> 0x71717171.
- Arbitration: req0=req1=1 held continuously after reset -> grants alternate 0,1,0,1 with one ack per 4 cycles; each ack goes only to its owner; neither requester is starved.
- Blink: BLINK_DIV=4, last write 0x1234, blink_en=1 -> writes alternate 0xFFFFFFFF / 0xF9A4B099 every 4 cycles. Drop blink_en during the blank phase -> one refresh writes 0xF9A4B099. A req0 arriving together with a refresh is served first.
- Abort: assert reset during WRITE -> chipselect deasserts, no ack. After release, req1 with 0x0000 -> 0xC0C0C0C0, ack1.
